// File: rtl/gorev_birimi_pkg.sv
// gorev_birimi_pkg: task codes, default frame size and the window type shared
// by the image task unit and its 3x3 window sub-module.
package gorev_birimi_pkg;

    localparam int VARSAYILAN_GENISLIK  = 320;
    localparam int VARSAYILAN_YUKSEKLIK = 240;

    // Task codes latched on basla; codes 5..7 fall back to pass-through
    typedef enum logic [2:0] {
        GRV0_GECIR   = 3'd0,
        GRV1_TERS    = 3'd1,
        GRV2_G_L     = 3'd2,
        GRV3_LAPLACE = 3'd3,
        GRV4_ESIK    = 3'd4
    } gorev_e;

    // 3x3 neighbourhood after border replacement (k=north, g=south, b=west, d=east, m=centre)
    typedef struct packed {
        logic [7:0] kb;
        logic [7:0] k;
        logic [7:0] kd;
        logic [7:0] b;
        logic [7:0] m;
        logic [7:0] d;
        logic [7:0] gb;
        logic [7:0] g;
        logic [7:0] gd;
    } pencere_t;

    // Clamp an unsigned 11-bit magnitude to the 8-bit pixel range
    function automatic logic [7:0] doyur8(input logic [10:0] deger);
        return (deger > 11'd255) ? 8'd255 : deger[7:0];
    endfunction

endpackage

// File: rtl/gorev_birimi_pencere_3x3.sv
// gorev_birimi_pencere_3x3: two line buffers, a sliding window and border
// replacement. The newest column comes straight from the line buffers and the
// incoming pixel, so the window of output k is complete in the same cycle that
// input k+GENISLIK+1 is accepted. Neighbours outside the image become the centre.
module gorev_birimi_pencere_3x3
    import gorev_birimi_pkg::*;
#(
    parameter int GENISLIK  = VARSAYILAN_GENISLIK,
    parameter int YUKSEKLIK = VARSAYILAN_YUKSEKLIK
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       temizle,
    input  logic       kabul,
    input  logic       ilerlet,
    input  logic       cikis,
    input  logic [7:0] pixel_i,
    output pencere_t   pencere
);

    localparam int XW = (GENISLIK  > 1) ? $clog2(GENISLIK)  : 1;
    localparam int YW = (YUKSEKLIK > 1) ? $clog2(YUKSEKLIK) : 1;
    localparam logic [XW-1:0] SON_SUTUN = XW'(GENISLIK - 1);
    localparam logic [YW-1:0] SON_SATIR = YW'(YUKSEKLIK - 1);

    logic [7:0]    satir1 [GENISLIK];
    logic [7:0]    satir2 [GENISLIK];
    logic [XW-1:0] giris_sutun;
    logic [XW-1:0] mrk_sutun;
    logic [YW-1:0] mrk_satir;
    logic [7:0]    sol  [3];
    logic [7:0]    orta [3];
    logic [7:0]    yeni_ust;
    logic [7:0]    yeni_orta;

    assign yeni_ust  = satir2[giris_sutun];
    assign yeni_orta = satir1[giris_sutun];

    // Line buffers: one row back and two rows back, written only by real pixels
    always_ff @(posedge clk_i) begin
        if (kabul) begin
            satir1[giris_sutun] <= pixel_i;
            satir2[giris_sutun] <= satir1[giris_sutun];
        end
    end

    // Input column pointer and centre position of the next output pixel
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            giris_sutun <= '0;
            mrk_sutun   <= '0;
            mrk_satir   <= '0;
        end else if (temizle) begin
            giris_sutun <= '0;
            mrk_sutun   <= '0;
            mrk_satir   <= '0;
        end else begin
            if (ilerlet) begin
                giris_sutun <= (giris_sutun == SON_SUTUN) ? '0 : giris_sutun + XW'(1);
            end
            if (cikis) begin
                if (mrk_sutun == SON_SUTUN) begin
                    mrk_sutun <= '0;
                    mrk_satir <= (mrk_satir == SON_SATIR) ? '0 : mrk_satir + YW'(1);
                end else begin
                    mrk_sutun <= mrk_sutun + XW'(1);
                end
            end
        end
    end

    // Shift the two older window columns left on every advance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) begin
                sol[i]  <= '0;
                orta[i] <= '0;
            end
        end else if (ilerlet) begin
            sol[0]  <= orta[0];
            sol[1]  <= orta[1];
            sol[2]  <= orta[2];
            orta[0] <= yeni_ust;
            orta[1] <= yeni_orta;
            orta[2] <= pixel_i;
        end
    end

    // Border replacement: a neighbour outside the frame takes the centre value
    always_comb begin
        logic ust_var;
        logic alt_var;
        logic sol_var;
        logic sag_var;
        logic [7:0] c;
        ust_var   = (mrk_satir != '0);
        alt_var   = (mrk_satir != SON_SATIR);
        sol_var   = (mrk_sutun != '0);
        sag_var   = (mrk_sutun != SON_SUTUN);
        c         = orta[1];
        pencere    = '0;
        pencere.m  = c;
        pencere.k  = ust_var ? orta[0] : c;
        pencere.g  = alt_var ? orta[2] : c;
        pencere.b  = sol_var ? sol[1]  : c;
        pencere.d  = sag_var ? yeni_orta : c;
        pencere.kb = (ust_var && sol_var) ? sol[0]   : c;
        pencere.kd = (ust_var && sag_var) ? yeni_ust : c;
        pencere.gb = (alt_var && sol_var) ? sol[2]   : c;
        pencere.gd = (alt_var && sag_var) ? pixel_i  : c;
    end

endmodule

// File: rtl/gorev_birimi.sv
// gorev_birimi: streaming per-frame image task unit. basla latches a task code;
// the next frame is passed through a point or 3x3 window operation and exactly
// GENISLIK*YUKSEKLIK results leave in raster order, the last GENISLIK+1 of them
// flushed without further input.
// Optional build macro GOREV_BITTI_EN adds bitti_o, a pulse on the final output.
module gorev_birimi
    import gorev_birimi_pkg::*;
#(
    parameter int GENISLIK  = VARSAYILAN_GENISLIK,
    parameter int YUKSEKLIK = VARSAYILAN_YUKSEKLIK
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       basla,
    input  logic       etkin_i,
    input  logic [7:0] pixel_i,
    input  logic [2:0] gorev_i,
    output logic       etkin_o,
    output logic [7:0] pixel_o
`ifdef GOREV_BITTI_EN
    ,
    output logic       bitti_o
`endif
);

    localparam int TOPLAM = GENISLIK * YUKSEKLIK;
    localparam int CW     = $clog2(TOPLAM + 1);
    localparam logic [CW-1:0] TOPLAM_S   = CW'(TOPLAM);
    localparam logic [CW-1:0] SON_S      = CW'(TOPLAM - 1);
    localparam logic [CW-1:0] GENISLIK_S = CW'(GENISLIK);

    logic [CW-1:0]  giris_say;
    logic [CW-1:0]  cikis_say;
    logic [2:0]     gorev_q;
    logic           kabul;
    logic           bosalt;
    logic           ilerlet;
    logic           cikis;
    pencere_t       p;
    logic [11:0]    gauss_top;
    logic signed [10:0] lap;
    logic [10:0]    lap_mut;
    logic [7:0]     sonuc;

    assign kabul   = etkin_i && !basla && (giris_say < TOPLAM_S);
    assign bosalt  = !basla && (giris_say == TOPLAM_S) && (cikis_say < TOPLAM_S);
    assign ilerlet = kabul || bosalt;
    assign cikis   = bosalt || (kabul && (giris_say > GENISLIK_S));

    gorev_birimi_pencere_3x3 #(
        .GENISLIK  (GENISLIK),
        .YUKSEKLIK (YUKSEKLIK)
    ) u_pencere (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .temizle (basla),
        .kabul   (kabul),
        .ilerlet (ilerlet),
        .cikis   (cikis),
        .pixel_i (pixel_i),
        .pencere (p)
    );

    // Task arithmetic on the current window: 1-2-1 Gaussian, 4-neighbour Laplace, threshold
    always_comb begin
        gauss_top = 12'(p.kb) + 12'(p.kd) + 12'(p.gb) + 12'(p.gd)
                  + (12'(p.k) << 1) + (12'(p.g) << 1) + (12'(p.b) << 1) + (12'(p.d) << 1)
                  + (12'(p.m) << 2) + 12'd8;
        lap       = $signed({1'b0, p.m, 2'b00})
                  - $signed({3'b000, p.k}) - $signed({3'b000, p.g})
                  - $signed({3'b000, p.b}) - $signed({3'b000, p.d});
        lap_mut   = lap[10] ? $unsigned(-lap) : $unsigned(lap);
        case (gorev_q)
            GRV1_TERS:    sonuc = 8'd255 - p.m;
            GRV2_G_L:     sonuc = 8'(gauss_top >> 4);
            GRV3_LAPLACE: sonuc = doyur8(lap_mut);
            GRV4_ESIK:    sonuc = p.m[7] ? 8'd255 : 8'd0;
            default:      sonuc = p.m;
        endcase
    end

    // Task register, frame counters and registered result outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gorev_q   <= GRV0_GECIR;
            giris_say <= '0;
            cikis_say <= '0;
            etkin_o   <= 1'b0;
            pixel_o   <= 8'd0;
`ifdef GOREV_BITTI_EN
            bitti_o   <= 1'b0;
`endif
        end else if (basla) begin
            gorev_q   <= gorev_i;
            giris_say <= '0;
            cikis_say <= '0;
            etkin_o   <= 1'b0;
`ifdef GOREV_BITTI_EN
            bitti_o   <= 1'b0;
`endif
        end else begin
            etkin_o <= cikis;
            if (kabul) begin
                giris_say <= giris_say + CW'(1);
            end
            if (cikis) begin
                cikis_say <= cikis_say + CW'(1);
                pixel_o   <= sonuc;
            end
`ifdef GOREV_BITTI_EN
            bitti_o <= cikis && (cikis_say == SON_S);
`endif
        end
    end

endmodule

// File: tb/tb_gorev_birimi.sv
// tb_gorev_birimi: scoreboard bench for gorev_birimi on a reduced 8x6 frame.
// Stimulus pushes model results into a queue; a monitor pops one entry per etkin_o.
module tb_gorev_birimi;
    import gorev_birimi_pkg::*;

    localparam int GEN    = 8;
    localparam int YUK    = 6;
    localparam int TOPLAM = GEN * YUK;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       basla;
    logic       etkin_i;
    logic [7:0] pixel_i;
    logic [2:0] gorev_i;
    logic       etkin_o;
    logic [7:0] pixel_o;
`ifdef GOREV_BITTI_EN
    logic       bitti_o;
`endif

    int kontrol = 0;
    int hata    = 0;
    int gonderilen = 0;
    int alinan     = 0;
    int exp_q[$];
    int kare     [TOPLAM];
    int sonuclar [TOPLAM];

    gorev_birimi #(
        .GENISLIK  (GEN),
        .YUKSEKLIK (YUK)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .basla   (basla),
        .etkin_i (etkin_i),
        .pixel_i (pixel_i),
        .gorev_i (gorev_i),
        .etkin_o (etkin_o),
        .pixel_o (pixel_o)
`ifdef GOREV_BITTI_EN
        ,
        .bitti_o (bitti_o)
`endif
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string ad, input int gercek, input int beklenen);
        kontrol++;
        if (gercek !== beklenen) begin
            hata++;
            $display("[TB] FAIL %s: gercek=%0d beklenen=%0d t=%0t", ad, gercek, beklenen, $time);
        end
    endtask

    // Neighbour fetch with the border rule: outside pixels become the centre
    function automatic int komsu(int r, int c, int dr, int dc);
        int rr = r + dr;
        int cc = c + dc;
        if (rr < 0 || rr >= YUK || cc < 0 || cc >= GEN) return kare[r*GEN + c];
        return kare[rr*GEN + cc];
    endfunction

    function automatic int model(logic [2:0] g, int idx);
        int r = idx / GEN;
        int c = idx % GEN;
        int m = kare[idx];
        int s;
        case (g)
            3'd1: return 255 - m;
            3'd2: begin
                s = komsu(r,c,-1,-1) + 2*komsu(r,c,-1,0) + komsu(r,c,-1,1)
                  + 2*komsu(r,c,0,-1) + 4*m + 2*komsu(r,c,0,1)
                  + komsu(r,c,1,-1) + 2*komsu(r,c,1,0) + komsu(r,c,1,1);
                return (s + 8) / 16;
            end
            3'd3: begin
                s = 4*m - komsu(r,c,-1,0) - komsu(r,c,1,0) - komsu(r,c,0,-1) - komsu(r,c,0,1);
                if (s < 0) s = -s;
                return (s > 255) ? 255 : s;
            end
            3'd4: return (m >= 128) ? 255 : 0;
            default: return m;
        endcase
    endfunction

    // tur 0: constant, 1: ramp (k*deger mod 256), 2: 127/128 alternating, 3: impulse at (2,3)
    task automatic kareDoldur(input int tur, input int deger);
        for (int k = 0; k < TOPLAM; k++) begin
            case (tur)
                0: kare[k] = deger;
                1: kare[k] = (k * deger) % 256;
                2: kare[k] = (k % 2 == 0) ? 127 : 128;
                default: kare[k] = (k == 2*GEN + 3) ? 255 : 0;
            endcase
        end
    endtask

    task automatic baslat(input logic [2:0] g);
        @(posedge clk_i); #1;
        basla   = 1'b1;
        gorev_i = g;
        etkin_i = 1'b1;
        pixel_i = 8'hAA;
        @(posedge clk_i); #1;
        basla      = 1'b0;
        etkin_i    = 1'b0;
        gonderilen = 0;
        alinan     = 0;
        checkOutput("basla_sonrasi_etkin", int'(etkin_o), 0);
    endtask

    task automatic applyStimulus(input logic [2:0] g, input bit bosluk);
        baslat(g);
        for (int k = 0; k < TOPLAM; k++) exp_q.push_back(model(g, k));
        for (int k = 0; k < TOPLAM; k++) begin
            if (bosluk && $urandom_range(0, 2) == 0) begin
                etkin_i = 1'b0;
                pixel_i = 8'h5A;
                @(posedge clk_i); #1;
            end
            etkin_i = 1'b1;
            pixel_i = 8'(kare[k]);
            @(posedge clk_i);
            gonderilen++;
            #1;
        end
        etkin_i = 1'b1;
        pixel_i = 8'h33;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk_i);
        etkin_i = 1'b0;
        checkOutput("kuyruk_bosalma", exp_q.size(), 0);
        repeat (GEN + 5) @(posedge clk_i);
        #1;
        checkOutput("cikis_adedi", alinan, TOPLAM);
        checkOutput("bitis_etkin", int'(etkin_o), 0);
    endtask

    // Monitor: pop and compare on every output, check first-output latency
    always @(negedge clk_i) begin
        if (etkin_o) begin
            if (exp_q.size() == 0) begin
                kontrol++;
                hata++;
                $display("[TB] FAIL beklenmeyen_cikis: gercek=%0d beklenen=yok t=%0t", pixel_o, $time);
            end else begin
                checkOutput("piksel", int'(pixel_o), exp_q.pop_front());
            end
            if (alinan == 0) checkOutput("ilk_cikis_gecikme", gonderilen, GEN + 2);
`ifdef GOREV_BITTI_EN
            checkOutput("bitti", int'(bitti_o), (alinan == TOPLAM - 1) ? 1 : 0);
`endif
            if (alinan < TOPLAM) sonuclar[alinan] = int'(pixel_o);
            alinan++;
        end
    end

    // Watchdog so the run always ends with a summary line
    initial begin
        #500000;
        hata++;
        $display("[TB] FAIL zaman_asimi: gercek=asildi beklenen=bitis");
        $display("Simulation finished: %0d checks, %0d errors", kontrol, hata);
        $finish;
    end

    initial begin
        int sifir_olmayan;
        rst_i   = 1'b1;
        basla   = 1'b0;
        etkin_i = 1'b0;
        pixel_i = 8'd0;
        gorev_i = 3'd0;
        #23;
        checkOutput("reset_etkin", int'(etkin_o), 0);
        checkOutput("reset_piksel", int'(pixel_o), 0);
        rst_i = 1'b0;

        kareDoldur(0, 100);
        applyStimulus(GRV2_G_L, 1'b0);
        checkOutput("gauss_sabit_tutma", int'(pixel_o), 100);

        kareDoldur(1, 1);
        applyStimulus(GRV1_TERS, 1'b0);
        checkOutput("ters_son", int'(pixel_o), 255 - (TOPLAM - 1));

        kareDoldur(0, 77);
        applyStimulus(GRV3_LAPLACE, 1'b0);
        checkOutput("laplace_sabit_son", int'(pixel_o), 0);

        kareDoldur(3, 0);
        applyStimulus(GRV3_LAPLACE, 1'b0);
        checkOutput("darbe_merkez", sonuclar[2*GEN + 3], 255);
        checkOutput("darbe_kuzey",  sonuclar[1*GEN + 3], 255);
        checkOutput("darbe_guney",  sonuclar[3*GEN + 3], 255);
        checkOutput("darbe_bati",   sonuclar[2*GEN + 2], 255);
        checkOutput("darbe_dogu",   sonuclar[2*GEN + 4], 255);
        sifir_olmayan = 0;
        for (int k = 0; k < TOPLAM; k++) if (sonuclar[k] != 0) sifir_olmayan++;
        checkOutput("darbe_sifir_olmayan", sifir_olmayan, 5);

        kareDoldur(2, 0);
        applyStimulus(GRV4_ESIK, 1'b0);
        checkOutput("esik_tek", sonuclar[1], 255);
        checkOutput("esik_cift", sonuclar[2], 0);
        checkOutput("esik_tutma", int'(pixel_o), 255);

        kareDoldur(1, 37);
        applyStimulus(GRV2_G_L, 1'b0);

        kareDoldur(1, 13);
        applyStimulus(GRV1_TERS, 1'b1);
        applyStimulus(3'd6, 1'b1);

        kareDoldur(1, 5);
        baslat(GRV1_TERS);
        for (int k = 0; k < TOPLAM; k++) exp_q.push_back(model(GRV1_TERS, k));
        for (int k = 0; k < 20; k++) begin
            etkin_i = 1'b1;
            pixel_i = 8'(kare[k]);
            @(posedge clk_i);
            gonderilen++;
            #1;
        end
        etkin_i = 1'b0;
        checkOutput("reset_oncesi_etkin", int'(etkin_o), 1);
        rst_i = 1'b1;
        #1;
        checkOutput("ara_reset_etkin", int'(etkin_o), 0);
        checkOutput("ara_reset_piksel", int'(pixel_o), 0);
        exp_q.delete();
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        kareDoldur(1, 29);
        applyStimulus(GRV3_LAPLACE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", kontrol, hata);
        $finish;
    end

endmodule

// File: doc/gorev_birimi.md
Name: gorev_birimi

Overview:
- Streaming per-frame image task unit for 8-bit grayscale frames (default 320x240), raster order, one pixel per accepted cycle.
- `basla` latches a task code. The following frame is then processed by a point operation or a 3x3 window operation.
- Exactly GENISLIK*YUKSEKLIK result pixels are emitted in raster order, including autonomous flushing after input ends.
- Sits between the camera/frame-memory reader and the result writer.

Parameters:
- GENISLIK, 320, pixels per row.
- YUKSEKLIK, 240, rows per frame.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- basla  in  1  one-cycle start pulse; latches gorev_i and clears counters.
- etkin_i  in  1  pixel_i valid this cycle.
- pixel_i  in  8  input pixel.
- gorev_i  in  3  task code, sampled only when basla=1.
- etkin_o  out  1  pixel_o valid this cycle.
- pixel_o  out  8  result pixel.

Behaviour:
- Reset (async, active-high):
  - etkin_o=0, pixel_o=0.
  - Input and output counters = 0.
  - Task register = GRV0_GECIR.
  - Line buffers need not be cleared.
- basla=1:
  - Task register <= gorev_i.
  - Counters cleared; any frame in progress is abandoned.
  - etkin_o=0 in the next cycle.
  - etkin_i is ignored while basla=1.
- Task codes:
  - 0 GRV0_GECIR: out = c.
  - 1 GRV1_TERS: out = 255-c.
  - 2 GRV2_G_L (Gaussian low-pass): out = (sum(k*p)+8)>>4 with kernel [1 2 1; 2 4 2; 1 2 1].
  - 3 GRV3_LAPLACE: out = min(255, |4c - N - S - E - W|), computed at 11-bit signed width.
  - 4 GRV4_ESIK: out = (c>=128) ? 255 : 0.
  - 5-7: treated as GRV0_GECIR.
- Border rule: any window neighbour outside the image is replaced by the centre pixel c.
- Pixel index: k = row*GENISLIK + col. Inputs are accepted only while input count < GENISLIK*YUKSEKLIK; extra etkin_i pixels are ignored.
- Uniform latency for all tasks: output k is emitted, etkin_o=1 for one cycle, in the cycle after input k+GENISLIK+1 is accepted.
- Gaps in etkin_i stall the window; no output is produced during gap cycles except when flushing.
- Flush: once the last input has been accepted, the remaining GENISLIK+1 outputs are emitted on consecutive cycles with no etkin_i required.
- After output count reaches GENISLIK*YUKSEKLIK: etkin_o=0; the unit idles until the next basla.
- pixel_o holds its last value when etkin_o=0.
- Storage: two GENISLIK-deep line buffers plus a 3x3 register window; single write port per buffer.

Optional Feature:
- Macro GOREV_BITTI_EN.
- Defined: extra output port bitti_o (1 bit), reset 0. It pulses high for exactly one cycle, in the same cycle as the final (GENISLIK*YUKSEKLIK-th) etkin_o.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Shared header sabitler.vh holds the task codes `GRV0_GECIR..`GRV4_ESIK (3'd0..3'd4; `GRV2_G_L = 3'd2) and default frame dimensions.
- One natural sub-module: pencere_3x3. It holds the line buffers, the window registers, the row/column position and border replacement, and advances on accept or flush strobe.
- The task arithmetic stays in gorev_birimi.

Test Plan:
- Reset, basla with gorev_i=`GRV2_G_L, 76800-pixel constant 100 frame -> exactly 76800 outputs, all 0x64. etkin_o falls and stays low afterwards.
- GRV1_TERS, ramp pixel = k mod 256 -> output k = 255-(k mod 256), in order. First etkin_o one cycle after input 321 is accepted.
- GRV3_LAPLACE, constant frame -> all 0. Single 0xFF at (100,100) in a zero frame -> centre 255 (sat), four neighbours 255, all else 0.
- GRV4_ESIK, pixels alternating 127/128 -> 0x00/0xFF alternating.
- Random one-cycle gaps in etkin_i -> same output sequence as the gapless run; total count 76800.
- rst_i asserted mid-frame -> etkin_o=0 immediately. A new basla plus full frame yields a correct 76800-pixel result.
